// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RV32I/E integer ALU with an optional iterative
// M-extension (one multiply or divide bit per cycle).
// Optional feature macro: ALU_MULDIV_EN. When undefined, op[4:3]=11 is invalid
// and the iteration datapath, counter and ITER state are not built.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             available,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             fault
);

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b01000, OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010, OP_SLTU = 5'b00011, OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101, OP_OR   = 5'b00110, OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01101, OP_BEQ  = 5'b10000, OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_BLT  = 5'b10100, OP_BGE  = 5'b10101, OP_BLTU = 5'b10110;
  localparam logic [4:0] OP_BGEU = 5'b10111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DONE  = 2'd2
`ifdef ALU_MULDIV_EN
    , ITER = 2'd3
`endif
  } state_t;

  state_t               state, state_next;
  logic [4:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q, base_res;
  logic [SHIFT_W-1:0]   shamt;
  logic                 op_valid;

  assign shamt = b_q[SHIFT_W-1:0];

  // Decode the live op so an invalid request can be flagged on the sampling edge.
  always_comb begin
    op_valid = 1'b0;
    casez (op)
      5'b00???, 5'b01000, 5'b01101, 5'b10000, 5'b10001, 5'b101??: op_valid = 1'b1;
`ifdef ALU_MULDIV_EN
      5'b11???: op_valid = 1'b1;
`endif
      default: op_valid = 1'b0;
    endcase
  end

  // Single-cycle base operations on the captured operands.
  always_comb begin
    base_res = '0;
    case (op_q)
      OP_ADD:  base_res = a_q + b_q;
      OP_SUB:  base_res = a_q - b_q;
      OP_SLL:  base_res = a_q << shamt;
      OP_SRL:  base_res = a_q >> shamt;
      OP_SRA:  base_res = $signed(a_q) >>> shamt;
      OP_XOR:  base_res = a_q ^ b_q;
      OP_OR:   base_res = a_q | b_q;
      OP_AND:  base_res = a_q & b_q;
      OP_SLT,
      OP_BLT:  base_res[0] = $signed(a_q) < $signed(b_q);
      OP_SLTU,
      OP_BLTU: base_res[0] = a_q < b_q;
      OP_BGE:  base_res[0] = $signed(a_q) >= $signed(b_q);
      OP_BGEU: base_res[0] = a_q >= b_q;
      OP_BEQ:  base_res[0] = a_q == b_q;
      OP_BNE:  base_res[0] = a_q != b_q;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHIFT_W-1:0] LAST = SHIFT_W'(WIDTH - 1);

  logic [SHIFT_W-1:0]   cnt;
  logic [WIDTH-1:0]     acc_hi, acc_lo, opnd, mag_a, mag_b, special_res;
  logic [WIDTH-1:0]     step_hi, step_lo, iter_res;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   prod;
  logic                 neg_res, is_m, is_div, is_rem, m_hi, a_sgn, b_sgn;
  logic                 a_neg, b_neg, div_zero, div_ovf, m_special;

  // M-op decode, operand magnitudes and the divide special cases.
  always_comb begin
    is_m        = op_q[4:3] == 2'b11;
    is_div      = op_q[2];
    is_rem      = op_q[1];
    m_hi        = op_q[1:0] != 2'b00;
    a_sgn       = is_div ? ~op_q[0] : (op_q[1] ^ op_q[0]);
    b_sgn       = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
    a_neg       = a_sgn & a_q[WIDTH-1];
    b_neg       = b_sgn & b_q[WIDTH-1];
    mag_a       = a_neg ? -a_q : a_q;
    mag_b       = b_neg ? -b_q : b_q;
    div_zero    = is_div && (b_q == '0);
    div_ovf     = is_div && ~op_q[0] && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
    m_special   = div_zero | div_ovf;
    if (div_zero) special_res = is_rem ? a_q : '1;
    else          special_res = is_rem ? '0 : a_q;
  end

  // One shift-add or restoring-subtract step, plus sign fix-up of the final step.
  always_comb begin
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    prod      = '0;
    iter_res  = '0;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
      iter_res = is_rem ? step_hi : step_lo;
      if (neg_res) iter_res = -iter_res;
    end else begin
      step_hi  = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
      prod     = {step_hi, step_lo};
      if (neg_res) prod = -prod;
      iter_res = m_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end
  end

  // Iteration registers: loaded in START, stepped in ITER.
  always_ff @(posedge clk) begin
    if (state == START) begin
      acc_hi  <= '0;
      acc_lo  <= is_div ? mag_a : mag_b;
      opnd    <= is_div ? mag_b : mag_a;
      neg_res <= (is_div && is_rem) ? a_neg : (a_neg ^ b_neg);
    end else if (state == ITER) begin
      acc_hi  <= step_hi;
      acc_lo  <= step_lo;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:  if (available) state_next = op_valid ? START : DONE;
      START: begin
        state_next = DONE;
`ifdef ALU_MULDIV_EN
        if (is_m && !m_special) state_next = ITER;
`endif
      end
`ifdef ALU_MULDIV_EN
      ITER:  if (cnt == LAST) state_next = DONE;
`endif
      DONE:  if (!available) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; operands are only read after being loaded here.
  always_ff @(posedge clk) begin
    // NOTE: datapath-only registers carry no reset; they are always written before being used.
    if (state == IDLE && available) begin
      op_q <= op;
      a_q  <= in_a;
      b_q  <= in_b;
    end
  end

  // Result, busy, fault and iteration counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out   <= '0;
      busy  <= 1'b0;
      fault <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (available) begin
          busy  <= op_valid;
          fault <= ~op_valid;
        end
        START: begin
`ifdef ALU_MULDIV_EN
          cnt <= '0;
          if (!(is_m && !m_special)) begin
            out  <= is_m ? special_res : base_res;
            busy <= 1'b0;
          end
`else
          out  <= base_res;
          busy <= 1'b0;
`endif
        end
`ifdef ALU_MULDIV_EN
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out  <= iter_res;
            busy <= 1'b0;
          end
        end
`endif
        DONE: if (!available) fault <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed-vector bench for alu_muldiv (WIDTH=32).
// M-op vectors are applied when ALU_MULDIV_EN is defined; otherwise M ops must fault.
module tb_alu_muldiv;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              available;
  logic [4:0]        op;
  logic [WIDTH-1:0]  in_a, in_b;
  logic [WIDTH-1:0]  out;
  logic              busy, fault;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  alu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .available (available),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out       (out),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs while busy, wait for busy to fall
  // (bounded), then drop available for one cycle.
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output logic busy0, output logic fault0);
    @(negedge clk);
    op = o; in_a = a; in_b = b; available = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy0 = busy;
    fault0 = fault;
    in_a = $urandom; in_b = $urandom; op = 5'($urandom);
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_a = $urandom; in_b = $urandom;
    end
    res = out;
    available = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; available = 1'b0; op = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h, expected 00000000", out); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_vec++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b, expected 0", fault); end
    reset_n = 1'b1;
  endtask

  task automatic test_base();
    vec_t v[16];
    logic [31:0] res;
    int lat;
    logic b0, f0;
    v[0]  = '{"ADD_wrap", 5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    v[1]  = '{"SRA",      5'b01101, 32'h80000000, 32'h00000004, 32'hF8000000, 1};
    v[2]  = '{"SUB",      5'b01000, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1};
    v[3]  = '{"SLL_31",   5'b00001, 32'h00000001, 32'h0000003F, 32'h80000000, 1};
    v[4]  = '{"SRL_1",    5'b00101, 32'h80000000, 32'h00000021, 32'h40000000, 1};
    v[5]  = '{"SLT",      5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    v[6]  = '{"SLTU",     5'b00011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    v[7]  = '{"XOR",      5'b00100, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1};
    v[8]  = '{"OR",       5'b00110, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1};
    v[9]  = '{"AND",      5'b00111, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1};
    v[10] = '{"BEQ",      5'b10000, 32'h00000005, 32'h00000005, 32'h00000001, 1};
    v[11] = '{"BNE",      5'b10001, 32'h00000005, 32'h00000005, 32'h00000000, 1};
    v[12] = '{"BLT",      5'b10100, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
    v[13] = '{"BGE",      5'b10101, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1};
    v[14] = '{"BLTU",     5'b10110, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1};
    v[15] = '{"BGEU",     5'b10111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
    for (int i = 0; i < 16; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, lat, b0, f0);
      n_vec++;
      if (res !== v[i].exp) begin
        n_err++; $display("FAIL %s_result: got %h, expected %h", v[i].name, res, v[i].exp);
      end
      n_vec++;
      if (b0 !== 1'b1 || f0 !== 1'b0 || lat != v[i].lat) begin
        n_err++;
        $display("FAIL %s_timing: busy@0=%b fault@0=%b busy fell after edge %0d, expected 1/0/%0d",
                 v[i].name, b0, f0, lat, v[i].lat);
      end
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    vec_t v[14];
    logic [31:0] res;
    int lat;
    logic b0, f0;
    v[0]  = '{"MUL",       5'b11000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    v[1]  = '{"MULHU",     5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    v[2]  = '{"MULH",      5'b11001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    v[3]  = '{"MULHSU",    5'b11010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    v[4]  = '{"DIV",       5'b11100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    v[5]  = '{"REM",       5'b11110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    v[6]  = '{"DIVU",      5'b11101, 32'd100,      32'd7,        32'd14,       33};
    v[7]  = '{"REMU",      5'b11111, 32'd100,      32'd7,        32'd2,        33};
    v[8]  = '{"DIV_ovf",   5'b11100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    v[9]  = '{"REM_ovf",   5'b11110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    v[10] = '{"REMU_zero", 5'b11111, 32'd7,        32'd0,        32'd7,        1};
    v[11] = '{"DIVU_zero", 5'b11101, 32'd7,        32'd0,        32'hFFFFFFFF, 1};
    v[12] = '{"DIV_zero",  5'b11100, 32'd7,        32'd0,        32'hFFFFFFFF, 1};
    v[13] = '{"DIV_neg",   5'b11100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, lat, b0, f0);
      n_vec++;
      if (res !== v[i].exp) begin
        n_err++; $display("FAIL %s_result: got %h, expected %h", v[i].name, res, v[i].exp);
      end
      n_vec++;
      if (b0 !== 1'b1 || f0 !== 1'b0 || lat != v[i].lat) begin
        n_err++;
        $display("FAIL %s_timing: busy@0=%b fault@0=%b busy fell after edge %0d, expected 1/0/%0d",
                 v[i].name, b0, f0, lat, v[i].lat);
      end
    end
  endtask
`else
  task automatic test_m_disabled();
    logic [31:0] res;
    int lat;
    logic b0, f0;
    for (int i = 0; i < 8; i++) begin
      run_op(5'b11000 | 5'(i), 32'd7, 32'd3, res, lat, b0, f0);
      n_vec++;
      if (f0 !== 1'b1 || b0 !== 1'b0) begin
        n_err++; $display("FAIL m_op_%0d_fault: fault=%b busy=%b, expected 1/0", i, f0, b0);
      end
    end
  endtask
`endif

  task automatic test_fault();
    logic [31:0] res;
    int lat;
    logic b0, f0;
    logic [4:0] bad [7];
    run_op(5'b00000, 32'd2, 32'd3, res, lat, b0, f0);
    n_vec++;
    if (res !== 32'd5) begin n_err++; $display("FAIL fault_pre_add: got %h, expected 00000005", res); end
    @(negedge clk);
    op = 5'b01001; in_a = 32'h12345678; in_b = 32'h9; available = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (fault !== 1'b1 || busy !== 1'b0 || out !== 32'd5) begin
      n_err++; $display("FAIL fault_raise: fault=%b busy=%b out=%h, expected 1/0/00000005", fault, busy, out);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (fault !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL fault_hold: fault=%b busy=%b, expected 1/0", fault, busy);
    end
    available = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (fault !== 1'b0 || out !== 32'd5) begin
      n_err++; $display("FAIL fault_clear: fault=%b out=%h, expected 0/00000005", fault, out);
    end
    bad = '{5'b01010, 5'b01011, 5'b01100, 5'b01110, 5'b01111, 5'b10010, 5'b10011};
    for (int i = 0; i < 7; i++) begin
      run_op(bad[i], 32'd1, 32'd1, res, lat, b0, f0);
      n_vec++;
      if (f0 !== 1'b1 || b0 !== 1'b0 || res !== 32'd5) begin
        n_err++; $display("FAIL invalid_%b: fault=%b busy=%b out=%h, expected 1/0/00000005", bad[i], f0, b0, res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    logic b0, f0;
    logic held_ok;
    @(negedge clk);
    op = 5'b00000; in_a = 32'd10; in_b = 32'd20; available = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out !== 32'd30 || busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_first: out=%h busy=%b, expected 0000001e/0", out, busy);
    end
    held_ok = 1'b1;
    in_a = 32'd99; in_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b0 || out !== 32'd30) held_ok = 1'b0;
    end
    n_vec++;
    if (held_ok !== 1'b1) begin
      n_err++; $display("FAIL b2b_no_reissue: out=%h busy=%b, expected 0000001e/0", out, busy);
    end
    available = 1'b0;
    @(posedge clk);
    run_op(5'b01000, 32'd30, 32'd50, res, lat, b0, f0);
    n_vec++;
    if (res !== 32'hFFFFFFEC || lat != 1) begin
      n_err++; $display("FAIL b2b_second: out=%h lat=%0d, expected ffffffec/1", res, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    logic b0, f0;
    @(negedge clk);
    op = 5'b00000; in_a = 32'h11; in_b = 32'h22; available = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; available = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out !== 32'h0 || busy !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL reset_in_start: out=%h busy=%b fault=%b, expected 0/0/0", out, busy, fault);
    end
    reset_n = 1'b1;
`ifdef ALU_MULDIV_EN
    @(negedge clk);
    op = 5'b11000; in_a = 32'd7; in_b = 32'hFFFFFFFD; available = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; available = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out !== 32'h0 || busy !== 1'b0 || fault !== 1'b0) begin
      n_err++; $display("FAIL reset_in_iter: out=%h busy=%b fault=%b, expected 0/0/0", out, busy, fault);
    end
    reset_n = 1'b1;
`endif
    run_op(5'b00000, 32'd2, 32'd3, res, lat, b0, f0);
    n_vec++;
    if (res !== 32'd5 || lat != 1) begin
      n_err++; $display("FAIL reset_recover_add: out=%h lat=%0d, expected 00000005/1", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_base();
`ifdef ALU_MULDIV_EN
    test_muldiv();
`else
    test_m_disabled();
`endif
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
